// File: rtl/bus_arbiter_pkg.sv
// Shared types and constants for the two-port L2 request arbiter.
package bus_arbiter_pkg;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned STRB_W = 4;
    localparam int unsigned NPORT  = 2;

    typedef logic [1:0] arb_state_t;

    localparam logic [1:0] ARB_IDLE = 2'd0;
    localparam logic [1:0] ARB_BUSY = 2'd1;
    localparam logic [1:0] ARB_RESP = 2'd2;

    // Port 0 is instruction fetch, port 1 is memory access.
    localparam logic ARB_PORT_IF = 1'b0;
    localparam logic ARB_PORT_MA = 1'b1;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic              we;
        logic [DATA_W-1:0] wdata;
        logic [STRB_W-1:0] wstrb;
    } mem_req_t;

endpackage

// File: rtl/arb_rr_select.sv
// Combinational round-robin pick between two requesters.
module arb_rr_select
    import bus_arbiter_pkg::*;
(
    input  logic [1:0] req_valid,
    input  logic       last_grant,
    output logic       any,
    output logic       winner
);

    // On a tie the port that did not win last time goes next.
    always_comb begin
        any    = |req_valid;
        winner = ARB_PORT_IF;
        if (req_valid == 2'b11) begin
            winner = ~last_grant;
        end else if (req_valid[ARB_PORT_MA]) begin
            winner = ARB_PORT_MA;
        end
    end

endmodule

// File: rtl/bus_arbiter.sv
// Two-port arbiter onto the single L2 cache port, with a hung-cache watchdog.
module bus_arbiter
    import bus_arbiter_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [1:0]              req_valid,
    input  logic [1:0][ADDR_W-1:0]  req_addr,
    input  logic [1:0]              req_we,
    input  logic [1:0][DATA_W-1:0]  req_wdata,
    input  logic [1:0][STRB_W-1:0]  req_wstrb,
    output logic [1:0]              req_ack,
    output logic [1:0][DATA_W-1:0]  req_rdata,
    output logic                    mem_valid,
    output logic [ADDR_W-1:0]       mem_addr,
    output logic                    mem_we,
    output logic [DATA_W-1:0]       mem_wdata,
    output logic [STRB_W-1:0]       mem_wstrb,
    input  logic                    mem_ack,
    input  logic [DATA_W-1:0]       mem_rdata,
    output logic                    error
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

    arb_state_t             state, state_d;
    logic                   grant, grant_d;
    logic                   last_grant, last_grant_d;
    logic [CNT_W-1:0]       cnt, cnt_d;
    mem_req_t               mem_req, mem_req_d;
    logic                   mem_valid_d;
    logic [1:0]             req_ack_d;
    logic [1:0][DATA_W-1:0] req_rdata_d;
    logic                   error_d;
    logic                   sel_any;
    logic                   sel_winner;

    arb_rr_select u_sel (
        .req_valid  (req_valid),
        .last_grant (last_grant),
        .any        (sel_any),
        .winner     (sel_winner)
    );

    assign mem_addr  = mem_req.addr;
    assign mem_we    = mem_req.we;
    assign mem_wdata = mem_req.wdata;
    assign mem_wstrb = mem_req.wstrb;

    // Next-state and next-output logic; ack beats watchdog expiry in the same cycle.
    always_comb begin
        state_d      = state;
        grant_d      = grant;
        last_grant_d = last_grant;
        cnt_d        = cnt;
        mem_req_d    = mem_req;
        mem_valid_d  = mem_valid;
        req_ack_d    = 2'b00;
        req_rdata_d  = req_rdata;
        error_d      = error;
        case (state)
            ARB_IDLE: begin
                if (sel_any) begin
                    mem_req_d.addr  = req_addr[sel_winner];
                    mem_req_d.we    = req_we[sel_winner];
                    mem_req_d.wdata = req_wdata[sel_winner];
                    mem_req_d.wstrb = req_wstrb[sel_winner];
                    mem_valid_d     = 1'b1;
                    grant_d         = sel_winner;
                    last_grant_d    = sel_winner;
                    cnt_d           = '0;
                    state_d         = ARB_BUSY;
                end
            end
            ARB_BUSY: begin
                if (mem_ack) begin
                    req_rdata_d[grant] = mem_rdata;
                    req_ack_d[grant]   = 1'b1;
                    mem_valid_d        = 1'b0;
                    state_d            = ARB_RESP;
                end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
                    req_rdata_d[grant] = '0;
                    req_ack_d[grant]   = 1'b1;
                    mem_valid_d        = 1'b0;
                    error_d            = 1'b1;
                    state_d            = ARB_RESP;
                end else begin
                    cnt_d = cnt + CNT_W'(1);
                end
            end
            ARB_RESP: begin
                state_d = ARB_IDLE;
            end
            default: begin
                state_d     = ARB_IDLE;
                mem_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ARB_IDLE;
            grant      <= ARB_PORT_IF;
            last_grant <= ARB_PORT_MA;
            cnt        <= '0;
            mem_req    <= '0;
            mem_valid  <= 1'b0;
            req_ack    <= 2'b00;
            req_rdata  <= '0;
            error      <= 1'b0;
        end else begin
            state      <= state_d;
            grant      <= grant_d;
            last_grant <= last_grant_d;
            cnt        <= cnt_d;
            mem_req    <= mem_req_d;
            mem_valid  <= mem_valid_d;
            req_ack    <= req_ack_d;
            req_rdata  <= req_rdata_d;
            error      <= error_d;
        end
    end

endmodule

// File: tb/tb_bus_arbiter.sv
// Scoreboard bench for bus_arbiter: port drivers, a cache model, and an output monitor.
module tb_bus_arbiter;
    import bus_arbiter_pkg::*;

    typedef struct {
        int          port;
        logic [31:0] rdata;
        logic        err;
    } ack_t;

    logic              clk = 1'b0;
    logic              rst;
    logic [1:0]        req_valid;
    logic [1:0][31:0]  req_addr;
    logic [1:0]        req_we;
    logic [1:0][31:0]  req_wdata;
    logic [1:0][3:0]   req_wstrb;
    logic [1:0]        req_ack;
    logic [1:0][31:0]  req_rdata;
    logic              mem_valid;
    logic [31:0]       mem_addr;
    logic              mem_we;
    logic [31:0]       mem_wdata;
    logic [3:0]        mem_wstrb;
    logic              mem_ack;
    logic [31:0]       mem_rdata;
    logic              error;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int rises = 0;
    int issued = 0;
    int last_vlen = 0;
    int lat [2];

    logic ack_en = 1'b1;
    int   ack_delay = 1;
    logic ack_norm = 1'b0;
    logic late_ack = 1'b0;

    mem_req_t pq [2][$];
    mem_req_t exp_mem_q [$];
    ack_t     exp_ack_q [$];

    bus_arbiter #(.TIMEOUT(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_addr  (req_addr),
        .req_we    (req_we),
        .req_wdata (req_wdata),
        .req_wstrb (req_wstrb),
        .req_ack   (req_ack),
        .req_rdata (req_rdata),
        .mem_valid (mem_valid),
        .mem_addr  (mem_addr),
        .mem_we    (mem_we),
        .mem_wdata (mem_wdata),
        .mem_wstrb (mem_wstrb),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata),
        .error     (error)
    );

    initial forever #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Cache model: data is a fixed function of the address, ack after ack_delay extra cycles.
    assign mem_rdata = (mem_addr == 32'h0000_0100) ? 32'hCAFE_F00D : ~mem_addr;
    assign mem_ack   = ack_norm | late_ack;

    initial begin
        int bc;
        bc = 0;
        forever begin
            @(posedge clk);
            #1;
            if (mem_valid === 1'b1) bc++;
            else bc = 0;
            ack_norm = ack_en && (mem_valid === 1'b1) && (bc == ack_delay + 1);
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Push one transaction; call in expected grant order.
    task automatic txn(input int p, input logic [31:0] addr, input logic we,
                       input logic [31:0] wdata, input logic [3:0] wstrb,
                       input logic [31:0] rdata, input logic err);
        mem_req_t r;
        ack_t     a;
        r.addr = addr; r.we = we; r.wdata = wdata; r.wstrb = wstrb;
        a.port = p; a.rdata = rdata; a.err = err;
        pq[p].push_back(r);
        exp_mem_q.push_back(r);
        exp_ack_q.push_back(a);
        issued++;
    endtask

    task automatic wait_drain(input string nm);
        bit ok;
        ok = 1'b0;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            if (pq[0].size() == 0 && pq[1].size() == 0 &&
                exp_mem_q.size() == 0 && exp_ack_q.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: drain timeout, got pending=%0d expected 0", nm,
                     exp_mem_q.size() + exp_ack_q.size());
        end
        @(negedge clk);
    endtask

    task automatic check_reset(input string nm);
        chk({nm, "_mem_valid"}, 32'(mem_valid), 32'd0);
        chk({nm, "_mem_addr"},  mem_addr, 32'd0);
        chk({nm, "_mem_we"},    32'(mem_we), 32'd0);
        chk({nm, "_mem_wdata"}, mem_wdata, 32'd0);
        chk({nm, "_mem_wstrb"}, 32'(mem_wstrb), 32'd0);
        chk({nm, "_req_ack"},   32'(req_ack), 32'd0);
        chk({nm, "_rdata0"},    req_rdata[0], 32'd0);
        chk({nm, "_rdata1"},    req_rdata[1], 32'd0);
        chk({nm, "_error"},     32'(error), 32'd0);
    endtask

    // Requester drivers: hold request until ack, then drop or present the next one.
    for (genvar g = 0; g < 2; g++) begin : g_drv
        logic        v = 1'b0;
        logic [31:0] a = '0;
        logic        w = 1'b0;
        logic [31:0] d = '0;
        logic [3:0]  s = '0;
        assign req_valid[g] = v;
        assign req_addr[g]  = a;
        assign req_we[g]    = w;
        assign req_wdata[g] = d;
        assign req_wstrb[g] = s;

        initial begin
            mem_req_t r;
            int       t0;
            bit       got;
            bit       aborted;
            forever begin
                @(posedge clk);
                #1;
                if (pq[g].size() > 0) begin
                    r = pq[g].pop_front();
                    v = 1'b1; a = r.addr; w = r.we; d = r.wdata; s = r.wstrb;
                    t0 = cyc; got = 1'b0; aborted = 1'b0;
                    for (int k = 0; k < 40; k++) begin
                        @(negedge clk);
                        if (req_ack[g] === 1'b1) begin got = 1'b1; break; end
                        if (rst === 1'b1) begin aborted = 1'b1; break; end
                    end
                    if (got) begin
                        lat[g] = cyc - t0;
                    end else if (!aborted) begin
                        checks++;
                        errors++;
                        $display("FAIL port%0d_ack_wait: got no ack expected ack within 40 cycles", g);
                    end
                end else begin
                    v = 1'b0;
                end
            end
        end
    end

    // Monitor: compare every new cache request and every ack against the scoreboard.
    initial begin
        logic     prev_v;
        int       vcnt;
        mem_req_t em;
        ack_t     ea;
        prev_v = 1'b0;
        vcnt = 0;
        forever begin
            @(negedge clk);
            if (mem_valid === 1'b1 && !prev_v) begin
                rises++;
                if (exp_mem_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL mem_unexpected: got mem_valid addr %h expected none", mem_addr);
                end else begin
                    em = exp_mem_q.pop_front();
                    chk("mem_addr",  mem_addr, em.addr);
                    chk("mem_we",    32'(mem_we), 32'(em.we));
                    chk("mem_wdata", mem_wdata, em.wdata);
                    chk("mem_wstrb", 32'(mem_wstrb), 32'(em.wstrb));
                end
            end
            if (mem_valid === 1'b1) vcnt++;
            else if (prev_v) begin last_vlen = vcnt; vcnt = 0; end
            prev_v = (mem_valid === 1'b1);
            if (req_ack !== 2'b00 && !$isunknown(req_ack)) begin
                if (exp_ack_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL ack_unexpected: got req_ack %b expected 00", req_ack);
                end else begin
                    ea = exp_ack_q.pop_front();
                    chk("ack_port",  32'(req_ack), 32'(2'b01 << ea.port));
                    chk("ack_rdata", req_rdata[ea.port], ea.rdata);
                    chk("ack_error", 32'(error), 32'(ea.err));
                end
            end
        end
    end

    initial begin
        bit seen;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset("reset");
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);

        // Contention from reset: port 0 first, then port 1 write; next tie to port 0.
        txn(0, 32'h0000_0000, 1'b0, 32'h0, 4'h0, 32'hFFFF_FFFF, 1'b0);
        txn(1, 32'h0000_2000, 1'b1, 32'h1234_5678, 4'hF, 32'hFFFF_DFFF, 1'b0);
        wait_drain("contention");
        chk("contention_lat0", 32'(lat[0]), 32'd3);
        txn(0, 32'h0000_0040, 1'b0, 32'h0, 4'h0, 32'hFFFF_FFBF, 1'b0);
        txn(1, 32'h0000_0044, 1'b0, 32'h0, 4'h0, 32'hFFFF_FFBB, 1'b0);
        wait_drain("tie2");

        // Single read, ack one cycle after mem_valid.
        txn(0, 32'h0000_0100, 1'b0, 32'h0, 4'h0, 32'hCAFE_F00D, 1'b0);
        wait_drain("single");
        chk("single_lat", 32'(lat[0]), 32'd3);

        // Fairness: last grant was port 0, so port 1 leads and they alternate.
        for (int i = 0; i < 5; i++) begin
            txn(1, 32'h0000_1800 + 32'(4 * i), 1'b0, 32'h0, 4'h0, ~(32'h0000_1800 + 32'(4 * i)), 1'b0);
            txn(0, 32'h0000_1000 + 32'(4 * i), 1'b0, 32'h0, 4'h0, ~(32'h0000_1000 + 32'(4 * i)), 1'b0);
        end
        wait_drain("fairness");

        // Timeout: cache never acks.
        ack_en = 1'b0;
        txn(0, 32'h0000_0500, 1'b0, 32'h0, 4'h0, 32'h0, 1'b1);
        wait_drain("timeout");
        chk("timeout_vlen", 32'(last_vlen), 32'd4);
        chk("timeout_error", 32'(error), 32'd1);
        ack_en = 1'b1;
        txn(1, 32'h0000_0600, 1'b1, 32'hAABB_CCDD, 4'h3, 32'hFFFF_F9FF, 1'b1);
        wait_drain("after_timeout");
        chk("error_sticky", 32'(error), 32'd1);
        chk("no_reissue", 32'(rises), 32'(issued));

        // Reset in the second BUSY cycle of a hung request.
        ack_en = 1'b0;
        begin
            mem_req_t r;
            r.addr = 32'h0000_3000; r.we = 1'b0; r.wdata = 32'h0; r.wstrb = 4'h0;
            pq[1].push_back(r);
            exp_mem_q.push_back(r);
        end
        seen = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (mem_valid === 1'b1) begin seen = 1'b1; break; end
        end
        chk("rst_mid_started", 32'(seen), 32'd1);
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        late_ack = 1'b1;
        @(negedge clk);
        check_reset("rst_mid");
        @(posedge clk);
        #1 late_ack = 1'b0;
        ack_en = 1'b1;
        @(negedge clk);
        chk("late_ack_ignored", 32'(req_ack), 32'd0);
        chk("late_ack_idle", 32'(mem_valid), 32'd0);

        // Fresh arbitration after reset: port 0 wins the tie.
        txn(0, 32'h0000_3200, 1'b0, 32'h0, 4'h0, 32'hFFFF_CDFF, 1'b0);
        txn(1, 32'h0000_3100, 1'b0, 32'h0, 4'h0, 32'hFFFF_CEFF, 1'b0);
        wait_drain("post_reset");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/bus_arbiter.md
# bus_arbiter

Two-port request arbiter sharing the single L2 cache port between the fetch stage (port 0, instruction reads) and the memory-access stage (port 1, loads/stores). It sits between the pipeline stages and `l2cache`. It round-robin grants one transaction at a time, registers the granted request onto the cache port, and returns the cache response to the winner. A watchdog flags a hung cache.

## Interface
Parameters:
- `TIMEOUT`, 255: max BUSY cycles waiting for `mem_ack` before abort; ≥1.

Ports (`rs[i]` = per-requester, i ∈ {0,1}, as packed `[1:0]` arrays):
- `clk`  in  1  sole clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req_valid[i]`  in  1  request pending; held with payload stable until `req_ack[i]`.
- `req_addr[i]`  in  32  byte address.
- `req_we[i]`  in  1  1 = write.
- `req_wdata[i]`  in  32  write data.
- `req_wstrb[i]`  in  4  byte enables (writes only).
- `req_ack[i]`  out  1  one-cycle response pulse.
- `req_rdata[i]`  out  32  read data, valid while `req_ack[i]`.
- `mem_valid`  out  1  cache request; held until `mem_ack`.
- `mem_addr`, `mem_we`, `mem_wdata`, `mem_wstrb`  out  32/1/32/4  granted payload, registered.
- `mem_ack`  in  1  cache completion pulse.
- `mem_rdata`  in  32  cache read data, valid with `mem_ack`.
- `error`  out  1  sticky timeout flag.

## Operation
- States: IDLE, BUSY, RESP.
- IDLE:
  - If no `req_valid`, stay.
  - Otherwise pick the winner. If exactly one port is valid, it wins. If both are valid, the port ≠ `last_grant` wins.
  - Latch the winner's payload into the `mem_*` registers, set `mem_valid`=1, `grant`=winner, `last_grant`=winner, clear the watchdog counter, and go to BUSY.
- BUSY:
  - `mem_valid` and `mem_*` stay constant.
  - On `mem_ack`: capture `mem_rdata` into `req_rdata[grant]`, set `req_ack[grant]`=1, `mem_valid`=0, and go to RESP.
  - Otherwise increment the counter. At counter == `TIMEOUT-1` with no ack: set `error`=1, `mem_valid`=0, `req_ack[grant]`=1 with `req_rdata`=0, and go to RESP.
- RESP:
  - `req_ack` is high for exactly this cycle and clears on exit.
  - No arbitration happens here. This lets the requester drop `req_valid` before the next IDLE sample, so a completed request is never reissued.
  - Next state is IDLE.
- `mem_ack` in IDLE or RESP is ignored.
- Writes complete identically to reads. `req_rdata` is don't-care for writes, but is still driven from `mem_rdata`.
- Non-granted port: its request stays pending with no ack and is served in the following arbitration. Round-robin bounds its wait to one foreign transaction.
- `error` stays sticky until `rst`. The arbiter keeps operating after a timeout.
- `req_rdata[i]` holds its last value when not acked.
- Widths: counter `$clog2(TIMEOUT+1)` bits, saturating is unnecessary because the watchdog aborts first.

## Timing
- Reset values:
  - state = IDLE, `last_grant` = 1 (port 0 wins the first tie), `grant` = 0.
  - `mem_valid`=0, `mem_addr`/`mem_wdata`=0, `mem_we`=0, `mem_wstrb`=0.
  - `req_ack`=2'b00, `req_rdata`=0, `error`=0, counter=0.
- Request sampled valid at edge of cycle 0 (IDLE): `mem_valid` is visible in cycle 1.
- `mem_ack` in BUSY cycle k: `req_ack` is visible in cycle k+1 (RESP), and IDLE is at k+2.
- Minimum request-to-ack latency is 2 cycles. Back-to-back grant spacing is 3 cycles minimum.
- Timeout: `mem_valid` was high for exactly `TIMEOUT` cycles, then abort ack follows the next cycle.
- `rst` mid-BUSY/RESP: next cycle everything is at reset values. `mem_valid` drops regardless of the cache; `l2cache` shares the same `rst`.
- Simultaneous `mem_ack` and watchdog expiry in the same cycle: the ack wins, with real data and no `error`.

## Structure
- In the shared `common.sv` package:
  - `typedef enum logic [1:0] {ARB_IDLE, ARB_BUSY, ARB_RESP} ArbState`.
  - Port constants `ARB_PORT_IF = 1'b0`, `ARB_PORT_MA = 1'b1`.
- One natural sub-module: `arb_rr_select`. It is combinational: (`req_valid[1:0]`, `last_grant`) → (`any`, `winner`), and is reusable if more ports are added.
- The FSM, payload registers and watchdog live in `bus_arbiter`.

## Test plan
- Single read: port 0 valid, addr 0x100; cache acks 1 cycle after `mem_valid` with rdata 0xCAFEF00D → `mem_addr`=0x100 in cycle 1, `req_ack[0]`=1 with rdata 0xCAFEF00D in cycle 3, asserted one cycle only.
- Contention: both ports valid from reset; port 0 addr 0x0, port 1 write addr 0x2000 wdata 0x12345678 wstrb 0xF → port 0 served first, then port 1 with `mem_we`=1 and matching payload; the next tie goes to port 0.
- Fairness: both ports continuously re-request for 10 transactions → grants strictly alternate 0,1,0,1…; no ack on the non-granted port.
- Held request not reissued: port 1 keeps `req_valid` high until it sees ack, then drops it → exactly one `mem_valid` assertion per request.
- Timeout: `TIMEOUT`=4, cache never acks → `mem_valid` high exactly 4 cycles; `req_ack` with rdata 0 and `error`=1 next cycle; `error` holds through later good transactions until `rst`.
- Reset mid-transaction: `rst` in the 2nd BUSY cycle → next cycle all outputs at reset values; a late `mem_ack` is ignored; fresh arbitration gives port 0 priority.
